// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the FIFO controller and its storage.
// No logic lives here; every consumer derives its pointer and count widths from these.
package fifo_pkg;

  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_MEM_DEPTH       = 4;
  localparam int DEF_ALMOST_EMPTY_TH = 1;
  localparam int DEF_PTR_W           = CeilLog2(DEF_MEM_DEPTH);
  localparam int DEF_CNT_W           = DEF_PTR_W + 1;

endpackage

// File: rtl/simple_dual_port_ram_single_clock.sv
// Single-clock dual-port RAM: write lands on the rising edge, read is combinational from read_addr.
// No reset and no backpressure; the controller decides when we is asserted.
module simple_dual_port_ram_single_clock #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[write_addr] <= data;
  end

  assign q = mem[read_addr];

endmodule

// File: rtl/fifo_ctrl.sv
// Show-ahead FIFO controller: data_out is the oldest word with zero read latency; flags register with count.
// Push is refused only when full without a same-cycle pop; refused pushes and pops set sticky error flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH       = DEF_MEM_DEPTH,
  parameter int ADDR_WIDTH      = CeilLog2(MEM_DEPTH),
  parameter int ALMOST_FULL_TH  = MEM_DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(MEM_DEPTH - 1);
  localparam cnt_t CNT_MAX  = cnt_t'(MEM_DEPTH);
  localparam cnt_t AF_TH    = cnt_t'(ALMOST_FULL_TH);
  localparam cnt_t AE_TH    = cnt_t'(ALMOST_EMPTY_TH);

  ptr_t wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  cnt_t count_nxt;
  logic pop_acc, push_acc, we;
  logic overflow_nxt, underflow_nxt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + ptr_t'(1));
  endfunction

  // When full, a same-cycle pop frees the slot: the old word is read before the edge writes over it.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  assign we       = push_acc & ~flush & ~reset;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_acc) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop_acc)  rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({push_acc, pop_acc})
        2'b10:   count_nxt = count + cnt_t'(1);
        2'b01:   count_nxt = count - cnt_t'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // A new error in the same cycle as clear_errors keeps the flag set.
  assign overflow_nxt  = (push & ~push_acc) | (overflow  & ~clear_errors);
  assign underflow_nxt = (pop  & ~pop_acc)  | (underflow & ~clear_errors);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CNT_MAX);
      almost_empty <= (count_nxt <= AE_TH);
      almost_full  <= (count_nxt >= AF_TH);
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

  simple_dual_port_ram_single_clock #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk        (clk),
    .we         (we),
    .write_addr (wr_ptr),
    .read_addr  (rd_ptr),
    .data       (data_in),
    .q          (data_out)
  );

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Synchronous single-clock FIFO controller that sequences the team's simple_dual_port_ram_single_clock storage block.
- Owns the write and read pointers, the occupancy counter, the status flags and the error flags.
- Drives the RAM's we, write_addr and read_addr.
- Presents a show-ahead push/pop interface to the surrounding design: data_out always shows the oldest entry while not empty.

Parameters:
DATA_WIDTH, 8, width of each stored word
MEM_DEPTH, 4, number of entries; any value >= 2, power of two not required
ADDR_WIDTH, CeilLog2(MEM_DEPTH), RAM address width
ALMOST_FULL_TH, MEM_DEPTH-1, almost_full asserted when count >= this value
ALMOST_EMPTY_TH, 1, almost_empty asserted when count <= this value

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
push  in  1  write request for data_in
data_in  in  DATA_WIDTH  word to enqueue
pop  in  1  read request; consumes the word currently on data_out
flush  in  1  synchronous clear of contents; flags and pointers only, RAM is untouched
clear_errors  in  1  synchronous clear of the sticky error flags
data_out  out  DATA_WIDTH  oldest entry; RAM q, combinational from rd_ptr
full  out  1  count == MEM_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= ALMOST_FULL_TH
almost_empty  out  1  count <= ALMOST_EMPTY_TH
count  out  ADDR_WIDTH+1  current occupancy, 0..MEM_DEPTH
overflow  out  1  sticky: a push was rejected
underflow  out  1  sticky: a pop was rejected

Behaviour:
Clock and reset: one clock; reset is asynchronous and active-high, named clk and reset.

Reset values:
- wr_ptr = 0, rd_ptr = 0, count = 0.
- empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- overflow = 0, underflow = 0.
- data_out is undefined while empty.
- Reset mid-operation discards all contents immediately; no RAM write occurs while reset is high (we forced low).

Accept rules, evaluated on registered state:
- pop_acc = pop & !empty.
- push_acc = push & (!full | pop_acc). A simultaneous push and pop while full is accepted: the read is combinational and the write lands at the edge, so the old word is consumed.
- At empty, push and pop together: push accepted, pop rejected, underflow set.

RAM drive:
- we = push_acc & !flush & !reset.
- write_addr = wr_ptr; read_addr = rd_ptr.

Pointer update on the rising edge:
- wr_ptr advances on push_acc; rd_ptr advances on pop_acc.
- Wrap-around: pointer == MEM_DEPTH-1 goes to 0; no power-of-two arithmetic is relied on.

count update:
- +1 on push_acc only; -1 on pop_acc only.
- Unchanged on both or neither.
- Never leaves 0..MEM_DEPTH.

Flags:
- Registered, derived from the next count, so they are valid in the same cycle as count.

Latency:
- A word pushed at edge N appears on data_out after edge N when the FIFO was empty.
- empty deasserts after edge N; pop is legal in cycle N+1.

Flush:
- Takes priority over push and pop.
- Next state: pointers 0, count 0, empty 1.
- The error flags are not cleared by flush.

Error flags:
- overflow sets on push & !push_acc; underflow sets on pop & !pop_acc.
- Both stay set until clear_errors or reset.
- If clear_errors and a new error occur in the same cycle, the flag remains set (set wins).

Decomposition:
- Shared package fifo_pkg: CeilLog2 function, ptr_t and cnt_t width constants, default threshold constants.
- One sub-module instance: simple_dual_port_ram_single_clock (DATA_WIDTH, MEM_DEPTH, ADDR_WIDTH passed through).
- Pointer/count/flag logic stays in fifo_ctrl.

Test Plan:
1. Reset, then push 0xA1,0xA2,0xA3,0xA4 (MEM_DEPTH=4) -> count 1,2,3,4; almost_full at count 3; full after 4th edge; data_out=0xA1 throughout.
2. From full, push 0x55 alone -> count stays 4, RAM unchanged, overflow=1. Then clear_errors -> overflow=0.
3. From full, push 0xB0 with pop -> data_out 0xA1 then 0xA2, count stays 4. Four further pops return 0xA2,0xA3,0xA4,0xB0, ending empty=1 with wr_ptr=rd_ptr=1 (wrap verified).
4. Empty, push 0x11 and pop same cycle -> count 1, data_out=0x11, underflow=1.
5. MEM_DEPTH=5: push/pop 12 words 0x00..0x0B at alternating rates -> output order identical, pointers wrap 4->0, count never exceeds 5.
6. Count 3, assert reset mid-burst with push high -> immediately count 0, empty=1, no write. Separately, flush with push at count 2 -> count 0, overflow unchanged.
